// File: rtl/fft_slice_packer.sv
// Packs SLICES consecutive complex FFT bins into one wide AXI-Stream beat, tracks frame framing,
// and buffers packed beats in a small FWFT FIFO. Define FFT_SLICE_PACKER_ERR_CNT_EN to add err_count.
module fft_slice_packer #(
  parameter int SLICES          = 8,
  parameter int SLICE_W         = 48,
  parameter int BEATS_PER_FRAME = 256,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SLICE_W-1:0]          s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [SLICES*SLICE_W-1:0]   m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        frame_start,
`ifdef FFT_SLICE_PACKER_ERR_CNT_EN
  output logic [15:0]                 err_count,
`endif
  output logic                        err_frame
);

  localparam int DATA_W = SLICES * SLICE_W;
  localparam int SLOT_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int BEAT_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLICES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_FRAME - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  logic [SLOT_W-1:0] slot_idx;
  logic [BEAT_W-1:0] beat_idx;
  logic [DATA_W-1:0] pack;
  logic [DATA_W-1:0] pack_merged;

  logic accept;
  logic at_frame_end;
  logic beat_done;
  logic beat_last;
  logic early_end;
  logic missing_last;
  logic push;
  logic pop;

  // Each entry holds {tlast, packed data}.
  logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fifo_count_next;
  logic [DATA_W:0]   fifo_head;

  // ---------------------------------------------------------------------------
  // Input side: handshake, framing decisions and slot merge
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    accept       = s_axis_tvalid && s_axis_tready;
    at_frame_end = (beat_idx == LAST_BEAT) && (slot_idx == LAST_SLOT);
    beat_done    = accept && ((slot_idx == LAST_SLOT) || s_axis_tlast);
    beat_last    = (beat_idx == LAST_BEAT) || s_axis_tlast;
    early_end    = accept && s_axis_tlast && !at_frame_end;
    missing_last = accept && at_frame_end && !s_axis_tlast;
    push         = beat_done;
    pop          = m_axis_tvalid && m_axis_tready;
  end

  // The pack register is cleared after every push, so slots above a short
  // beat's last bin are already zero when it is pushed.
  always_comb begin
    pack_merged = pack;
    pack_merged[slot_idx*SLICE_W +: SLICE_W] = s_axis_tdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_idx    <= '0;
      beat_idx    <= '0;
      pack        <= '0;
      frame_start <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      frame_start <= accept && (slot_idx == '0) && (beat_idx == '0);
      err_frame   <= early_end || missing_last;
      if (accept) begin
        if (beat_done) begin
          pack     <= '0;
          slot_idx <= '0;
          beat_idx <= beat_last ? '0 : beat_idx + 1'b1;
        end else begin
          pack     <= pack_merged;
          slot_idx <= slot_idx + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Packed-beat FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_count_next = fifo_count;
    case ({push, pop})
      2'b10:   fifo_count_next = fifo_count + 1'b1;
      2'b01:   fifo_count_next = fifo_count - 1'b1;
      default: fifo_count_next = fifo_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      fifo_count <= fifo_count_next;
      // Registered, but computed from the next count so it never lags a push.
      s_axis_tready <= (fifo_count_next < DEPTH_C);
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; outputs are masked while the FIFO is empty instead.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {beat_last, pack_merged};
    end
  end

  always_comb begin
    fifo_head     = fifo_mem[rd_ptr];
    m_axis_tvalid = (fifo_count != '0);
    m_axis_tdata  = m_axis_tvalid ? fifo_head[DATA_W-1:0] : '0;
    m_axis_tlast  = m_axis_tvalid && fifo_head[DATA_W];
  end

`ifdef FFT_SLICE_PACKER_ERR_CNT_EN
  // Saturating count of framing errors; cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_frame && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_slice_packer.sv
// Directed self-checking bench for fft_slice_packer: framing, short beats, backpressure and reset.
// Also checks err_count when FFT_SLICE_PACKER_ERR_CNT_EN is defined.
module tb_fft_slice_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [47:0]  s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         s_tready;
  logic [383:0] m_tdata;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready = 1'b0;
  logic         frame_start;
  logic         err_frame;
`ifdef FFT_SLICE_PACKER_ERR_CNT_EN
  logic [15:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [383:0] rx_data [$];
  bit           rx_last [$];
  int           acc_cnt = 0;
  int           fs_cnt = 0;
  int           ef_cnt = 0;
  int           max_occ = 0;

  fft_slice_packer dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .frame_start   (frame_start),
`ifdef FFT_SLICE_PACKER_ERR_CNT_EN
    .err_count     (err_count),
`endif
    .err_frame     (err_frame)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    int occ;
    if (!rst) begin
      occ = acc_cnt / 8 - rx_data.size();
      if (occ > max_occ) max_occ = occ;
      if (s_tvalid && s_tready) acc_cnt++;
      if (m_tvalid && m_tready) begin
        rx_data.push_back(m_tdata);
        rx_last.push_back(m_tlast);
      end
      if (frame_start) fs_cnt++;
      if (err_frame) ef_cnt++;
    end
  end

  function automatic logic [47:0] bin_val(input int n);
    logic [23:0] re;
    logic [23:0] im;
    re = n[23:0];
    im = re + 24'h800000;
    return {im, re};
  endfunction

  function automatic logic [383:0] exp_beat(input int first, input int nvalid);
    logic [383:0] b;
    b = '0;
    for (int k = 0; k < 8; k++)
      if (k < nvalid) b[k*48 +: 48] = bin_val(first + k);
    return b;
  endfunction

  task automatic clear_monitor();
    rx_data.delete();
    rx_last.delete();
    acc_cnt = 0;
    fs_cnt  = 0;
    ef_cnt  = 0;
    max_occ = 0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    clear_monitor();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Presents one bin and returns #1 after the edge that accepted it; leaves tvalid high.
  task automatic send_bin(input logic [47:0] d, input bit last);
    bit ok;
    int i;
    ok = 0;
    i  = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!ok && i < 200) begin
      @(negedge clk);
      if (s_tready) ok = 1;
      i++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_axis_tready stayed 0 for %0d cycles", i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stop_input();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int i;
    i = 0;
    while (rx_data.size() < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (rx_data.size() != n) begin
      errors++;
      $display("FAIL beat_count: got %0d beats, expected %0d", rx_data.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b expected 0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b expected 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_m_tlast: got %b expected 0", m_tlast); end
    checks++; if (m_tdata !== 384'd0) begin errors++; $display("FAIL rst_m_tdata: got %h expected 0", m_tdata); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start: got %b expected 0", frame_start); end
    checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL rst_err_frame: got %b expected 0", err_frame); end
`ifdef FFT_SLICE_PACKER_ERR_CNT_EN
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rst_err_count: got %0d expected 0", err_count); end
`endif
    rst = 1'b0;
    #2;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rel_s_tready: got %b expected 0 before first clk", s_tready); end
    @(posedge clk);
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rel_s_tready_clk: got %b expected 1", s_tready); end
  endtask

  task automatic test_full_frame();
    do_reset();
    m_tready = 1'b1;
    for (int n = 0; n < 2048; n++) send_bin(bin_val(n), n == 2047);
    stop_input();
    wait_beats(256, 200);
    for (int b = 0; b < 256 && b < rx_data.size(); b++) begin
      checks++;
      if (rx_data[b] !== exp_beat(8*b, 8)) begin
        errors++; $display("FAIL full_data beat %0d: got %h expected %h", b, rx_data[b], exp_beat(8*b, 8));
      end
      checks++;
      if (rx_last[b] !== (b == 255)) begin
        errors++; $display("FAIL full_tlast beat %0d: got %b expected %b", b, rx_last[b], b == 255);
      end
    end
    checks++; if (fs_cnt != 1) begin errors++; $display("FAIL full_frame_start: got %0d pulses expected 1", fs_cnt); end
    checks++; if (ef_cnt != 0) begin errors++; $display("FAIL full_err_frame: got %0d pulses expected 0", ef_cnt); end
  endtask

  task automatic test_early_tlast();
    do_reset();
    m_tready = 1'b0;
    for (int n = 0; n < 8; n++) send_bin(bin_val(n), 1'b0);
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL latency_m_tvalid: got %b expected 1", m_tvalid); end
    for (int n = 8; n < 14; n++) send_bin(bin_val(n), n == 13);
    stop_input();
    m_tready = 1'b1;
    wait_beats(2, 50);
    if (rx_data.size() >= 2) begin
      checks++; if (rx_data[0] !== exp_beat(0, 8)) begin errors++; $display("FAIL early_beat0: got %h expected %h", rx_data[0], exp_beat(0, 8)); end
      checks++; if (rx_last[0] !== 1'b0) begin errors++; $display("FAIL early_tlast0: got %b expected 0", rx_last[0]); end
      checks++; if (rx_data[1] !== exp_beat(8, 6)) begin errors++; $display("FAIL early_short_beat: got %h expected %h", rx_data[1], exp_beat(8, 6)); end
      checks++; if (rx_last[1] !== 1'b1) begin errors++; $display("FAIL early_tlast1: got %b expected 1", rx_last[1]); end
    end
    checks++; if (ef_cnt != 1) begin errors++; $display("FAIL early_err_frame: got %0d pulses expected 1", ef_cnt); end
    for (int n = 500; n < 508; n++) send_bin(bin_val(n), 1'b0);
    stop_input();
    wait_beats(3, 50);
    if (rx_data.size() >= 3) begin
      checks++; if (rx_data[2] !== exp_beat(500, 8)) begin errors++; $display("FAIL early_restart_beat: got %h expected %h", rx_data[2], exp_beat(500, 8)); end
    end
    checks++; if (fs_cnt != 2) begin errors++; $display("FAIL early_frame_start: got %0d pulses expected 2", fs_cnt); end
    checks++; if (ef_cnt != 1) begin errors++; $display("FAIL early_err_after: got %0d pulses expected 1", ef_cnt); end
  endtask

  task automatic test_missing_tlast();
    do_reset();
    m_tready = 1'b1;
    for (int n = 0; n < 2056; n++) send_bin(bin_val(n), 1'b0);
    stop_input();
    wait_beats(257, 200);
    if (rx_data.size() == 257) begin
      checks++; if (rx_last[254] !== 1'b0) begin errors++; $display("FAIL miss_tlast254: got %b expected 0", rx_last[254]); end
      checks++; if (rx_last[255] !== 1'b1) begin errors++; $display("FAIL miss_tlast255: got %b expected 1", rx_last[255]); end
      checks++; if (rx_data[255] !== exp_beat(2040, 8)) begin errors++; $display("FAIL miss_beat255: got %h expected %h", rx_data[255], exp_beat(2040, 8)); end
      checks++; if (rx_data[256] !== exp_beat(2048, 8)) begin errors++; $display("FAIL miss_beat256: got %h expected %h", rx_data[256], exp_beat(2048, 8)); end
      checks++; if (rx_last[256] !== 1'b0) begin errors++; $display("FAIL miss_tlast256: got %b expected 0", rx_last[256]); end
    end
    checks++; if (ef_cnt != 1) begin errors++; $display("FAIL miss_err_frame: got %0d pulses expected 1", ef_cnt); end
    checks++; if (fs_cnt != 2) begin errors++; $display("FAIL miss_frame_start: got %0d pulses expected 2", fs_cnt); end
`ifdef FFT_SLICE_PACKER_ERR_CNT_EN
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL miss_err_count: got %0d expected 1", err_count); end
`endif
  endtask

  task automatic test_backpressure();
    int n;
    bit acc;
    logic [383:0] held;
    do_reset();
    m_tready = 1'b0;
    n = 0;
    held = '0;
    s_tlast  = 1'b0;
    s_tdata  = bin_val(0);
    s_tvalid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      acc = s_tready;
      if (c == 50) held = m_tdata;
      @(posedge clk);
      #1;
      if (acc) begin
        n++;
        s_tdata = bin_val(n);
      end
    end
    stop_input();
    checks++; if (n != 32) begin errors++; $display("FAIL bp_accepted: got %0d bins expected 32", n); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_s_tready: got %b expected 0", s_tready); end
    checks++; if (m_tdata !== held) begin errors++; $display("FAIL bp_stable: got %h expected %h", m_tdata, held); end
    checks++; if (held !== exp_beat(0, 8)) begin errors++; $display("FAIL bp_head: got %h expected %h", held, exp_beat(0, 8)); end
    checks++; if (max_occ != 4) begin errors++; $display("FAIL bp_occupancy: got %0d expected 4", max_occ); end
    m_tready = 1'b1;
    wait_beats(4, 50);
    for (int b = 0; b < 4 && b < rx_data.size(); b++) begin
      checks++;
      if (rx_data[b] !== exp_beat(8*b, 8) || rx_last[b] !== 1'b0) begin
        errors++; $display("FAIL bp_beat %0d: got %h/%b expected %h/0", b, rx_data[b], rx_last[b], exp_beat(8*b, 8));
      end
    end
  endtask

  task automatic test_full_pop();
    int n;
    bit acc;
    do_reset();
    n = 0;
    s_tlast  = 1'b0;
    s_tdata  = bin_val(0);
    s_tvalid = 1'b1;
    for (int c = 0; c < 300 || (n % 8) != 0; c++) begin
      m_tready = (c >= 300) ? 1'b1 : ((c >= 40) ? c[0] : 1'b0);
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      if (acc) begin
        n++;
        s_tdata = bin_val(n);
      end
      if (c > 1000) break;
    end
    stop_input();
    m_tready = 1'b1;
    wait_beats(n / 8, 100);
    checks++; if (max_occ != 4) begin errors++; $display("FAIL fp_max_occupancy: got %0d expected 4", max_occ); end
    for (int b = 0; b < rx_data.size() && b < n / 8; b++) begin
      checks++;
      if (rx_data[b] !== exp_beat(8*b, 8) || rx_last[b] !== 1'b0) begin
        errors++; $display("FAIL fp_beat %0d: got %h/%b expected %h/0", b, rx_data[b], rx_last[b], exp_beat(8*b, 8));
      end
    end
  endtask

  task automatic test_reset_mid_beat();
    do_reset();
    m_tready = 1'b0;
    for (int n = 0; n < 29; n++) send_bin(bin_val(n), 1'b0);
    stop_input();
    rst = 1'b1;
    #2;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL mid_rst_s_tready: got %b expected 0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_m_tvalid: got %b expected 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL mid_rst_m_tlast: got %b expected 0", m_tlast); end
    checks++; if (m_tdata !== 384'd0) begin errors++; $display("FAIL mid_rst_m_tdata: got %h expected 0", m_tdata); end
    checks++; if (frame_start !== 1'b0 || err_frame !== 1'b0) begin errors++; $display("FAIL mid_rst_pulses: got %b%b expected 00", frame_start, err_frame); end
    @(posedge clk);
    clear_monitor();
    #1 rst = 1'b0;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL mid_rel_s_tready: got %b expected 1", s_tready); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rx_data.size() != 0) begin errors++; $display("FAIL mid_no_beat: got %0d beats expected 0", rx_data.size()); end
    for (int n = 900; n < 908; n++) send_bin(bin_val(n), 1'b0);
    stop_input();
    wait_beats(1, 50);
    if (rx_data.size() >= 1) begin
      checks++; if (rx_data[0] !== exp_beat(900, 8)) begin errors++; $display("FAIL mid_first_beat: got %h expected %h", rx_data[0], exp_beat(900, 8)); end
    end
    checks++; if (fs_cnt != 1) begin errors++; $display("FAIL mid_frame_start: got %0d pulses expected 1", fs_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_early_tlast();
    test_missing_tlast();
    test_backpressure();
    test_full_pop();
    test_reset_mid_beat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
